// File: rtl/psum_acc_ctrl.sv
// Multi-pass partial-sum accumulation sequencer: launches one macro pass at a time, sums the
// per-channel results and hands the totals downstream. Define PSUM_ACC_SAT_EN to saturate.
module psum_acc_ctrl #(
    parameter int unsigned CHANNEL_NUM = 128,
    parameter int unsigned IN_WIDTH    = 6,
    parameter int unsigned ACC_WIDTH   = 10,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 start,
    input  logic [3:0]           pass_cfg,
    output logic                 busy,
    output logic                 macro_start,
    output logic [3:0]           macro_pass_idx,
    input  logic                 psum_valid,
    input  logic [IN_WIDTH-1:0]  psum_in [CHANNEL_NUM],
    output logic [ACC_WIDTH-1:0] acc_out [CHANNEL_NUM],
    output logic                 acc_out_valid,
    input  logic                 acc_out_ready,
    output logic                 done,
    output logic                 timeout_err
);

    localparam int unsigned TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {StIdle, StLaunch, StWait, StOutput} state_e;

    state_e               state_q, state_d;
    logic [3:0]           pass_lim_q, pass_lim_d;
    logic [3:0]           pass_cnt_q, pass_cnt_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 busy_q, busy_d;
    logic                 mstart_q, mstart_d;
    logic [3:0]           idx_q, idx_d;
    logic                 valid_q, valid_d;
    logic                 done_q, done_d;
    logic                 err_q, err_d;
    logic [ACC_WIDTH-1:0] acc_q   [CHANNEL_NUM];
    logic [ACC_WIDTH-1:0] acc_d   [CHANNEL_NUM];
    logic [ACC_WIDTH-1:0] acc_sum [CHANNEL_NUM];

    for (genvar c = 0; c < CHANNEL_NUM; c++) begin : g_add
`ifdef PSUM_ACC_SAT_EN
        logic [ACC_WIDTH:0] wide;
        assign wide       = {1'b0, acc_q[c]} + (ACC_WIDTH + 1)'(psum_in[c]);
        // Adds are non-negative, so a clamped channel stays clamped for the rest of the job.
        assign acc_sum[c] = wide[ACC_WIDTH] ? {ACC_WIDTH{1'b1}} : wide[ACC_WIDTH-1:0];
`else
        assign acc_sum[c] = acc_q[c] + ACC_WIDTH'(psum_in[c]);
`endif
    end

    always_comb begin
        state_d    = state_q;
        pass_lim_d = pass_lim_q;
        pass_cnt_d = pass_cnt_q;
        timer_d    = timer_q;
        busy_d     = busy_q;
        mstart_d   = 1'b0;
        idx_d      = 4'd0;
        valid_d    = valid_q;
        done_d     = 1'b0;
        err_d      = err_q;
        for (int c = 0; c < CHANNEL_NUM; c++) begin
            acc_d[c] = acc_q[c];
        end

        unique case (state_q)
            StIdle: begin
                // The done cycle still belongs to the finished job; a start there is dropped.
                if (start && !done_q) begin
                    pass_lim_d = pass_cfg;
                    pass_cnt_d = 4'd0;
                    err_d      = 1'b0;
                    busy_d     = 1'b1;
                    mstart_d   = 1'b1;
                    idx_d      = 4'd0;
                    state_d    = StLaunch;
                    for (int c = 0; c < CHANNEL_NUM; c++) begin
                        acc_d[c] = '0;
                    end
                end
            end
            StLaunch: begin
                timer_d = '0;
                state_d = StWait;
            end
            StWait: begin
                if (psum_valid) begin
                    for (int c = 0; c < CHANNEL_NUM; c++) begin
                        acc_d[c] = acc_sum[c];
                    end
                    if (pass_cnt_q == pass_lim_q) begin
                        valid_d = 1'b1;
                        state_d = StOutput;
                    end else begin
                        pass_cnt_d = pass_cnt_q + 4'd1;
                        mstart_d   = 1'b1;
                        idx_d      = pass_cnt_q + 4'd1;
                        state_d    = StLaunch;
                    end
                end else if (timer_q == TW'(TIMEOUT - 2)) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            StOutput: begin
                if (acc_out_ready) begin
                    valid_d = 1'b0;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= StIdle;
            pass_lim_q <= 4'd0;
            pass_cnt_q <= 4'd0;
            timer_q    <= '0;
            busy_q     <= 1'b0;
            mstart_q   <= 1'b0;
            idx_q      <= 4'd0;
            valid_q    <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                acc_q[c] <= '0;
            end
        end else begin
            state_q    <= state_d;
            pass_lim_q <= pass_lim_d;
            pass_cnt_q <= pass_cnt_d;
            timer_q    <= timer_d;
            busy_q     <= busy_d;
            mstart_q   <= mstart_d;
            idx_q      <= idx_d;
            valid_q    <= valid_d;
            done_q     <= done_d;
            err_q      <= err_d;
            for (int c = 0; c < CHANNEL_NUM; c++) begin
                acc_q[c] <= acc_d[c];
            end
        end
    end

    assign busy           = busy_q;
    assign macro_start    = mstart_q;
    assign macro_pass_idx = idx_q;
    assign acc_out_valid  = valid_q;
    assign done           = done_q;
    assign timeout_err    = err_q;
    assign acc_out        = acc_q;

endmodule
